periph_bus_bridge: RTL

- Downstream partner of the pipeline's memory-stall controller.
- Captures a load/store aimed at the peripheral region (chip-select 0) while the pipeline is stalled.
- Runs that access as a multi-cycle req/gnt/rvalid transaction on the peripheral bus, then returns a one-cycle ack with aligned, extended read data. The ack releases the stall.

---
 rtl/periph_bus_bridge.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge
//   Turns a stalled pipeline load/store aimed at chip-select 0 into a
//   req/gnt/rvalid transaction on the peripheral bus. When the transaction
//   finishes, it returns a one-cycle ack with aligned, sign/zero-extended
//   load data. The ack releases the stall.
//
// Optional feature macro: PERIPH_BUS_TIMEOUT_EN
//   When defined, a wait of TIMEOUT_CYCLES cycles for bus_gnt (in REQ) or for
//   bus_rvalid (in RDWAIT) completes the access with err=1.
//   When undefined, the bridge waits indefinitely.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid, rden, wren     pipeline request (wren wins if both are set)
//   addr, wdata, funct3       byte address, right-aligned store data, size/sign code
//   ack, rdata, err           one-cycle completion; rdata/err valid only with ack
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   peripheral bus request side
//   bus_gnt, bus_rvalid, bus_rdata                 peripheral bus response side

module periph_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              rden,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        funct3,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // rden is implied by req_valid & ~wren; only wren selects the operation.
  logic unused_rden;
  assign unused_rden = rden;

  // ---------------------------------------------------------------------------
  // Request decode (used only when a request is captured in IDLE)
  // ---------------------------------------------------------------------------
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_bad;

  always_comb begin
    cap_be    = 4'b1111;
    cap_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        cap_be    = 4'b0001 << addr[1:0];
        cap_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        cap_be    = addr[1] ? 4'b1100 : 4'b0011;
        cap_wdata = {2{wdata[15:0]}};
      end
      default: begin
        cap_be    = 4'b1111;
        cap_wdata = wdata;
      end
    endcase
    // Misaligned half/word, reserved codes 011/11x, or an unsigned store.
    cap_bad = (funct3[1:0] == 2'b01 && addr[0])
            || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            || (funct3 == 3'b011)
            || (funct3[2:1] == 2'b11)
            || (funct3[2] && wren);
  end

  // ---------------------------------------------------------------------------
  // Load data: pick the lane from the captured offset, then extend
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = bus_rdata[7:0];
      2'b01:   lane_b = bus_rdata[15:8];
      2'b10:   lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_ext = {24'h0, lane_b};
      3'b101:  ld_ext = {16'h0, lane_h};
      default: ld_ext = bus_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait-cycle timeout
  // ---------------------------------------------------------------------------
  logic to_hit;

`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts the wait cycles already spent in the current state. When it
  // equals TIMEOUT_CYCLES-1, the current cycle is the last allowed one.
  assign to_hit = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == REQ && state_q != REQ) || (state_d == RDWAIT && state_q != RDWAIT))
      cnt_d = '0;
    else if (state_q == REQ || state_q == RDWAIT)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = wren;
          addr_d  = addr;
          f3_d    = funct3;
          wdata_d = cap_wdata;
          be_d    = cap_be;
          if (cap_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (bus_rvalid) begin
            // Data arriving alongside the grant skips RDWAIT.
            state_d = DONE;
            rdata_d = ld_ext;
          end else begin
            state_d = RDWAIT;
          end
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RDWAIT: begin
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = ld_ext;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: begin
        // req_valid is ignored here because the stalled instruction is still
        // presented in this cycle.
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // bus_req decodes straight from state, so an asynchronous reset drops it
  // at once.
  assign ack       = (state_q == DONE);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule
